avg_divider_seq: RTL and testbench

Sequential, parametrised unsigned divider for the SMA datapath. It replaces fixed power-of-two shifting when the averaging window is not a power of two. It accepts a sum and a run-time divisor (window length) over a valid/ready handshake. Power-of-two divisors take a one-cycle shift fast path; other divisors use a radix-2 restoring divider. Optional round-half-up mode is supported. It sits between the adder tree and the SMA output register.

---
 rtl/avg_divider_seq.sv | 143 ++++++++++++++
 tb/tb_avg_divider_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/avg_divider_seq.sv
// Sequential unsigned divider for the SMA datapath: one-cycle shift for power-of-two
// windows, radix-2 restoring division otherwise, optional round-half-up.
module avg_divider_seq #(
    parameter int DIVIDEND_WIDTH = 10,
    parameter int DIVISOR_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic                      round_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [VW-1:0] dsr_p0;
    logic          rnd_p0;
    logic [DW-1:0] dvd_p0;
    logic [DW-1:0] quo_p0;
    logic [VW-1:0] prem_p0;

    logic          accept;
    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          qbit;
    logic [VW-1:0] nrem;
    logic [DW-1:0] nquo;

    function automatic logic [DW-1:0] round_q(input logic [DW-1:0] q, input logic [VW-1:0] r,
                                              input logic [VW-1:0] d, input logic en);
        logic [VW:0] r2;
        r2 = {r, 1'b0};
        return (en && (r2 >= {1'b0, d})) ? q + DW'(1) : q;
    endfunction

    function automatic logic is_pow2(input logic [VW-1:0] d);
        return (d != '0) && ((d & (d - 1'b1)) == '0);
    endfunction

    function automatic logic [DW-1:0] shr_pow2(input logic [DW-1:0] n, input logic [VW-1:0] d);
        logic [DW-1:0] res;
        res = n;
        for (int i = 0; i < VW; i++)
            if (d[i]) res = n >> i;
        return res;
    endfunction

    assign accept = (state == IDLE) && in_valid && in_ready;

    // Restoring step: the trial value is VW+1 bits; since partial remainder < divisor,
    // trial < 2*divisor and the sign of trial-divisor alone decides the quotient bit.
    always_comb begin
        trial = {prem_p0, dvd_p0[DW-1]};
        diff  = trial - {1'b0, dsr_p0};
        qbit  = ~diff[VW];
        nrem  = qbit ? diff[VW-1:0] : trial[VW-1:0];
        nquo  = {quo_p0[DW-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                        end else if (is_pow2(divisor)) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= round_q(shr_pow2(dividend, divisor),
                                                   dividend[VW-1:0] & (divisor - 1'b1),
                                                   divisor, round_en);
                            remainder   <= dividend[VW-1:0] & (divisor - 1'b1);
                            div_by_zero <= 1'b0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= round_q(nquo, nrem, dsr_p0, rnd_p0);
                        remainder   <= nrem;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working registers of the iterative divider; contents only matter while in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            dsr_p0  <= divisor;
            rnd_p0  <= round_en;
            dvd_p0  <= dividend;
            quo_p0  <= '0;
            prem_p0 <= '0;
        end else if (state == CALC) begin
            dvd_p0  <= {dvd_p0[DW-2:0], 1'b0};
            quo_p0  <= nquo;
            prem_p0 <= nrem;
        end
    end
endmodule

// File: tb/tb_avg_divider_seq.sv
// Directed-vector and randomised bench for avg_divider_seq at default widths.
module tb_avg_divider_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] dividend;
    logic [3:0] divisor;
    logic       round_en;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avg_divider_seq #(.DIVIDEND_WIDTH(10), .DIVISOR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .round_en(round_en),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [9:0] dvd;
        logic [3:0] dsr;
        logic       rnd;
        int         q;
        int         r;
        int         dbz;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [9:0] dvd, input logic [3:0] dsr, input logic rnd);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        round_en = rnd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 10'($urandom);
        divisor  = 4'($urandom);
        round_en = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_hs", int'(in_ready), 1);
        chk("out_valid_after_hs", int'(out_valid), 0);
    endtask

    task automatic check_res(input string tag, input int q, input int r, input int dbz);
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_quotient"}, int'(quotient), q);
        chk({tag, "_remainder"}, int'(remainder), r);
        chk({tag, "_div_by_zero"}, int'(div_by_zero), dbz);
        chk({tag, "_in_ready_low"}, int'(in_ready), 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        start_req(v.dvd, v.dsr, v.rnd);
        wait_result(lat);
        chk({tag, "_latency"}, lat, v.lat);
        check_res(tag, v.q, v.r, v.dbz);
        handshake();
    endtask

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hold;
        int eq, er, edbz, elat;
        logic [9:0] rd;
        logic [3:0] rs;
        logic       rr;

        vecs[0]  = '{10'd1000, 4'd4,  1'b0, 250,  0, 0, 1};
        vecs[1]  = '{10'd1022, 4'd4,  1'b1, 256,  2, 0, 1};
        vecs[2]  = '{10'd1000, 4'd7,  1'b0, 142,  6, 0, 11};
        vecs[3]  = '{10'd1000, 4'd7,  1'b1, 143,  6, 0, 11};
        vecs[4]  = '{10'd1023, 4'd3,  1'b0, 341,  0, 0, 11};
        vecs[5]  = '{10'd1023, 4'd15, 1'b0, 68,   3, 0, 11};
        vecs[6]  = '{10'd513,  4'd0,  1'b1, 1023, 1, 1, 1};
        vecs[7]  = '{10'd20,   4'd5,  1'b0, 4,    0, 0, 11};
        vecs[8]  = '{10'd100,  4'd10, 1'b1, 10,   0, 0, 11};
        vecs[9]  = '{10'd1023, 4'd1,  1'b1, 1023, 0, 0, 1};
        vecs[10] = '{10'd7,    4'd9,  1'b1, 1,    7, 0, 11};
        vecs[11] = '{10'd1023, 4'd8,  1'b1, 128,  7, 0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; round_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_after_edge", int'(in_ready), 1);

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure with a competing request held on the input
        start_req(10'd1000, 4'd7, 1'b0);
        wait_result(lat);
        chk("bp_latency", lat, 11);
        in_valid = 1'b1; dividend = 10'd20; divisor = 4'd5; round_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_res($sformatf("bp_hold%0d", c), 142, 6, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_after_hs", int'(in_ready), 1);
        chk("bp_out_valid_after_hs", int'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp_second_latency", lat, 11);
        check_res("bp_second", 4, 0, 0);
        handshake();

        // Reset in the middle of an iterative division
        start_req(10'd1000, 4'd7, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_rise", int'(in_ready), 1);
        chk("midrst_no_stale", int'(out_valid), 0);
        run_vec("post_rst", vecs[8]);

        // Randomised operands with random consumer stalls
        for (int n = 0; n < 500; n++) begin
            rd = 10'($urandom);
            rs = 4'($urandom);
            rr = 1'($urandom);
            if (rs == 0) begin
                eq = 1023; er = int'(rd) % 16; edbz = 1; elat = 1;
            end else begin
                eq = int'(rd) / int'(rs);
                er = int'(rd) % int'(rs);
                if (rr && (2 * er >= int'(rs))) eq = eq + 1;
                edbz = 0;
                elat = ($countones(rs) == 1) ? 1 : 11;
            end
            start_req(rd, rs, rr);
            wait_result(lat);
            chk($sformatf("rnd%0d_latency", n), lat, elat);
            chk($sformatf("rnd%0d_quotient", n), int'(quotient), eq);
            chk($sformatf("rnd%0d_remainder", n), int'(remainder), er);
            chk($sformatf("rnd%0d_div_by_zero", n), int'(div_by_zero), edbz);
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            chk($sformatf("rnd%0d_held_quotient", n), int'(quotient), eq);
            chk($sformatf("rnd%0d_held_valid", n), int'(out_valid), 1);
            handshake();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
